layer_train_sequencer: RTL and testbench

Initiator side of the layer valid/ack protocol: drives one 7x9 packed layer through a full training step and collects both results. Per host `start`, it issues a forward multiply, acks the forward result, issues backprop with the target vector, acks the delta vector, then accumulates an absolute-error sum. It sits between the host/sample buffer and a single `MatMul_Module` instance.

---
 rtl/layer_train_sequencer_pkg.sv | 35 +++
 rtl/layer_train_sequencer_err_accum.sv | 59 +++++
 rtl/layer_train_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_layer_train_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_train_sequencer_pkg.sv
// layer_train_sequencer_pkg
// Shared definitions for the layer training sequencer.
//   PK_WIDTH / PK_LEN / PK_BITS : packed vector geometry (7-bit signed x 9 = 63 bits)
//   IDX_W / ERR_W               : element index width and error-sum width
//   seq_state_t                 : sequencer state enumeration
//   pk_elem()                   : select element idx out of a packed vector
// Element i of a packed vector occupies bits [i*PK_WIDTH +: PK_WIDTH].
package layer_train_sequencer_pkg;

  localparam int PK_WIDTH = 7;
  localparam int PK_LEN   = 9;
  localparam int PK_BITS  = PK_WIDTH * PK_LEN;
  localparam int IDX_W    = 4;
  // 9 * 64 = 576 fits in 10 bits.
  localparam int ERR_W    = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE_FWD,
    ST_WAIT_FWD,
    ST_ACK_FWD,
    ST_BP_DRIVE,
    ST_ACK_BP,
    ST_ERR_ACC,
    ST_DONE
  } seq_state_t;

  function automatic logic signed [PK_WIDTH-1:0] pk_elem(
    input logic [PK_BITS-1:0] vec,
    input logic [IDX_W-1:0]   idx
  );
    return vec[int'(idx)*PK_WIDTH +: PK_WIDTH];
  endfunction

endpackage

// File: rtl/layer_train_sequencer_err_accum.sv
// seq_err_accum
// Walks the captured delta vector one element per cycle and accumulates the
// absolute value of each element.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_clear      : zero the index and the accumulator
//   i_start      : accumulate element [index] this cycle and advance
//   i_delta      : packed delta vector (held stable while accumulating)
//   o_sum        : running sum of |delta[i]|
//   o_finished   : high in the cycle the last element is being added
module seq_err_accum
  import layer_train_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clear,
  input  logic               i_start,
  input  logic [PK_BITS-1:0] i_delta,
  output logic [ERR_W-1:0]   o_sum,
  output logic               o_finished
);

  logic [IDX_W-1:0]  r_idx;
  logic [ERR_W-1:0]  r_sum;
  logic [PK_WIDTH:0] w_abs [PK_LEN];
  logic              w_last;

  // Absolute value of every element, computed one bit wider so that the most
  // negative element (-64) maps to +64 instead of wrapping.
  genvar gi;
  generate
    for (gi = 0; gi < PK_LEN; gi++) begin : g_abs
      logic signed [PK_WIDTH-1:0] w_elem;
      logic signed [PK_WIDTH:0]   w_ext;
      assign w_elem    = pk_elem(i_delta, IDX_W'(gi));
      assign w_ext     = {w_elem[PK_WIDTH-1], w_elem};
      assign w_abs[gi] = w_ext[PK_WIDTH] ? -w_ext : w_ext;
    end
  endgenerate

  assign w_last     = (r_idx == IDX_W'(PK_LEN - 1));
  assign o_finished = i_start & w_last;
  assign o_sum      = r_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_sum <= '0;
    end else if (i_clear) begin
      r_idx <= '0;
      r_sum <= '0;
    end else if (i_start) begin
      r_sum <= r_sum + ERR_W'(w_abs[r_idx]);
      if (!w_last) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/layer_train_sequencer.sv
// layer_train_sequencer
// Initiator side of the layer valid/ack protocol. One host start runs a
// forward multiply, acks it, runs backprop with the target vector, acks the
// delta, then sums |delta[i]| over the 9 elements.
// Ports:
//   clk, reset (async, active-low)
//   start, sample_in, target_in          : host request (start sampled in IDLE)
//   busy, done, fwd_result, delta_result, err_sum, timeout : host results
//   layer_mult, layer_backprop, layer_ack, layer_output_layer, layer_data_out
//                                        : requests to the layer
//   layer_data_in, layer_valid           : layer results
// All outputs are registered. Output registers are decoded from the next
// state so that each output is high during the state it belongs to.
// Build option: define SEQ_TIMEOUT_EN to bound the wait for layer_valid to
// TIMEOUT_CYCLES cycles; otherwise waits are unbounded and timeout is 0.
module layer_train_sequencer #(
  parameter int PK_WIDTH       = 7,
  parameter int PK_LEN         = 9,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int OUTPUT_LAYER   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [PK_WIDTH*PK_LEN-1:0]   sample_in,
  input  logic [PK_WIDTH*PK_LEN-1:0]   target_in,
  output logic                         busy,
  output logic                         done,
  output logic [PK_WIDTH*PK_LEN-1:0]   fwd_result,
  output logic [PK_WIDTH*PK_LEN-1:0]   delta_result,
  output logic [9:0]                   err_sum,
  output logic                         timeout,
  output logic                         layer_mult,
  output logic                         layer_backprop,
  output logic                         layer_ack,
  output logic                         layer_output_layer,
  output logic [PK_WIDTH*PK_LEN-1:0]   layer_data_out,
  input  logic [PK_WIDTH*PK_LEN-1:0]   layer_data_in,
  input  logic                         layer_valid
);

  import layer_train_sequencer_pkg::*;

  localparam int VEC_W = PK_WIDTH * PK_LEN;

  seq_state_t       r_state;
  seq_state_t       w_state_next;

  logic [VEC_W-1:0] r_sample;
  logic [VEC_W-1:0] r_target;
  logic [VEC_W-1:0] w_sample_cur;
  logic [VEC_W-1:0] r_fwd_result;
  logic [VEC_W-1:0] r_delta_result;
  logic [VEC_W-1:0] r_data_out;
  logic             r_busy;
  logic             r_done;
  logic             r_mult;
  logic             r_backprop;
  logic             r_ack;
  logic             r_timeout;
  logic             r_out_layer;

  logic             w_acc_finished;
  logic [9:0]       w_err_sum;
  logic             w_timeout_hit;
  logic             w_waiting;

  assign w_waiting = (r_state == ST_WAIT_FWD) || (r_state == ST_BP_DRIVE);

`ifdef SEQ_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] r_wait_cnt;

  // Cleared in the state before each wait so the count starts at 0 on entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt <= '0;
    end else if ((r_state == ST_ISSUE_FWD) || (r_state == ST_ACK_FWD)) begin
      r_wait_cnt <= '0;
    end else if (w_waiting && !layer_valid) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  assign w_timeout_hit = w_waiting && !layer_valid &&
                         (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = ^32'(TIMEOUT_CYCLES) ^ w_waiting;
  assign w_timeout_hit        = 1'b0;
`endif

  // The latched sample is not available yet in the cycle start is accepted.
  assign w_sample_cur = (r_state == ST_IDLE) ? sample_in : r_sample;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:      if (start) w_state_next = ST_ISSUE_FWD;
      ST_ISSUE_FWD: w_state_next = ST_WAIT_FWD;
      ST_WAIT_FWD: begin
        if (layer_valid)        w_state_next = ST_ACK_FWD;
        else if (w_timeout_hit) w_state_next = ST_IDLE;
      end
      // layer_valid is deliberately ignored here: the layer only drops it
      // after seeing the ack.
      ST_ACK_FWD:   w_state_next = ST_BP_DRIVE;
      ST_BP_DRIVE: begin
        if (layer_valid)        w_state_next = ST_ACK_BP;
        else if (w_timeout_hit) w_state_next = ST_IDLE;
      end
      ST_ACK_BP:    w_state_next = ST_ERR_ACC;
      ST_ERR_ACC:   if (w_acc_finished) w_state_next = ST_DONE;
      ST_DONE:      w_state_next = ST_IDLE;
      default:      w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sample       <= '0;
      r_target       <= '0;
      r_fwd_result   <= '0;
      r_delta_result <= '0;
      r_data_out     <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_mult         <= 1'b0;
      r_backprop     <= 1'b0;
      r_ack          <= 1'b0;
      r_timeout      <= 1'b0;
      r_out_layer    <= (OUTPUT_LAYER != 0);
    end else begin
      r_out_layer <= (OUTPUT_LAYER != 0);
      r_timeout   <= w_timeout_hit;
      r_mult      <= (w_state_next == ST_ISSUE_FWD);
      r_backprop  <= (w_state_next == ST_BP_DRIVE);
      r_ack       <= (w_state_next == ST_ACK_FWD) || (w_state_next == ST_ACK_BP);
      r_done      <= (w_state_next == ST_DONE);
      r_busy      <= (w_state_next != ST_IDLE) && (w_state_next != ST_DONE);

      if ((r_state == ST_IDLE) && start) begin
        r_sample <= sample_in;
        r_target <= target_in;
      end

      if ((r_state == ST_WAIT_FWD) && layer_valid) begin
        r_fwd_result <= layer_data_in;
      end
      if ((r_state == ST_BP_DRIVE) && layer_valid) begin
        r_delta_result <= layer_data_in;
      end

      unique case (w_state_next)
        ST_ISSUE_FWD, ST_WAIT_FWD, ST_ACK_FWD: r_data_out <= w_sample_cur;
        ST_BP_DRIVE, ST_ACK_BP:                r_data_out <= r_target;
        default:                               r_data_out <= '0;
      endcase
    end
  end

  seq_err_accum u_err_accum (
    .clk        (clk),
    .rst_n      (reset),
    .i_clear    (r_state == ST_ACK_BP),
    .i_start    (r_state == ST_ERR_ACC),
    .i_delta    (r_delta_result),
    .o_sum      (w_err_sum),
    .o_finished (w_acc_finished)
  );

  assign busy               = r_busy;
  assign done               = r_done;
  assign fwd_result         = r_fwd_result;
  assign delta_result       = r_delta_result;
  assign err_sum            = w_err_sum;
  assign timeout            = r_timeout;
  assign layer_mult         = r_mult;
  assign layer_backprop     = r_backprop;
  assign layer_ack          = r_ack;
  assign layer_output_layer = r_out_layer;
  assign layer_data_out     = r_data_out;

endmodule

// File: tb/tb_layer_train_sequencer.sv
// tb_layer_train_sequencer
// Drives randomized and directed training steps into layer_train_sequencer,
// acting as both host and layer. Expected results come from plain integer
// arithmetic over the element values and from cycle arithmetic relative to
// start and to each valid.
module tb_layer_train_sequencer;

  localparam int W = 7;
  localparam int L = 9;
  localparam int B = W * L;
`ifdef SEQ_TIMEOUT_EN
  localparam int TO       = 16;
  localparam int LONG_LAT = 12;
`else
  localparam int TO       = 255;
  localparam int LONG_LAT = 20;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [B-1:0] sample_in = '0;
  logic [B-1:0] target_in = '0;
  logic [B-1:0] layer_data_in = '0;
  logic         layer_valid = 1'b0;

  logic         busy, done, timeout;
  logic         layer_mult, layer_backprop, layer_ack, layer_output_layer;
  logic [B-1:0] fwd_result, delta_result, layer_data_out;
  logic [9:0]   err_sum;

  int n_checks = 0;
  int n_pass   = 0;

  layer_train_sequencer #(
    .PK_WIDTH(W), .PK_LEN(L), .TIMEOUT_CYCLES(TO), .OUTPUT_LAYER(1)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .sample_in(sample_in), .target_in(target_in),
    .busy(busy), .done(done), .fwd_result(fwd_result),
    .delta_result(delta_result), .err_sum(err_sum), .timeout(timeout),
    .layer_mult(layer_mult), .layer_backprop(layer_backprop),
    .layer_ack(layer_ack), .layer_output_layer(layer_output_layer),
    .layer_data_out(layer_data_out), .layer_data_in(layer_data_in),
    .layer_valid(layer_valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [B-1:0] pack(input int e[L]);
    logic [B-1:0] p;
    p = '0;
    for (int i = 0; i < L; i++) p[i*W +: W] = W'(e[i]);
    return p;
  endfunction

  function automatic int abs_sum(input int e[L]);
    int s;
    s = 0;
    for (int i = 0; i < L; i++) s += (e[i] < 0) ? -e[i] : e[i];
    return s;
  endfunction

  function automatic logic [B-1:0] rand_vec();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[B-1:0];
  endfunction

  // Protocol invariants, checked every cycle out of reset.
  logic prev_valid = 1'b0;
  always @(posedge clk) prev_valid <= layer_valid;
  always @(negedge clk) begin
    if (reset) begin
      check_eq("mult_bp_exclusive", 64'(layer_mult & layer_backprop), 64'd0);
      if (layer_ack) check_eq("ack_after_valid", 64'(prev_valid), 64'd1);
    end
  end

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_busy"},    64'(busy), 64'd0);
    check_eq({tag, "_done"},    64'(done), 64'd0);
    check_eq({tag, "_timeout"}, 64'(timeout), 64'd0);
    check_eq({tag, "_mult"},    64'(layer_mult), 64'd0);
    check_eq({tag, "_bp"},      64'(layer_backprop), 64'd0);
    check_eq({tag, "_ack"},     64'(layer_ack), 64'd0);
    check_eq({tag, "_outlay"},  64'(layer_output_layer), 64'd1);
    check_eq({tag, "_dout"},    64'(layer_data_out), 64'd0);
    check_eq({tag, "_fwd"},     64'(fwd_result), 64'd0);
    check_eq({tag, "_delta"},   64'(delta_result), 64'd0);
    check_eq({tag, "_errsum"},  64'(err_sum), 64'd0);
  endtask

  // One training step. Starts at the negedge of the IDLE cycle in which start
  // is raised; fl/bl are the layer's answer latencies in cycles after it
  // first sees mult/backprop.
  task automatic run_step(input logic [B-1:0] s, input logic [B-1:0] t,
                          input logic [B-1:0] fwd, input logic [B-1:0] dl,
                          input int exp_sum, input int fl, input int bl,
                          input bit poke, input bit hold_next, input bit rst_bp);
    @(negedge clk);
    check_eq("idle_busy", 64'(busy), 64'd0);
    check_eq("idle_mult", 64'(layer_mult), 64'd0);
    check_eq("idle_done", 64'(done), 64'd0);
    start = 1'b1; sample_in = s; target_in = t;
    @(negedge clk);                                  // cycle 1
    start = poke; sample_in = ~s; target_in = ~t;
    check_eq("c1_mult", 64'(layer_mult), 64'd1);
    check_eq("c1_busy", 64'(busy), 64'd1);
    check_eq("c1_dout", 64'(layer_data_out), 64'(s));
    check_eq("c1_bp",   64'(layer_backprop), 64'd0);
    repeat (fl) begin
      @(negedge clk);
      check_eq("fw_mult", 64'(layer_mult), 64'd0);
      check_eq("fw_ack",  64'(layer_ack), 64'd0);
      check_eq("fw_bp",   64'(layer_backprop), 64'd0);
      check_eq("fw_dout", 64'(layer_data_out), 64'(s));
    end
    layer_valid = 1'b1; layer_data_in = fwd;
    @(negedge clk);                                  // forward ack cycle
    start = 1'b0;
    check_eq("fack_ack", 64'(layer_ack), 64'd1);
    check_eq("fack_fwd", 64'(fwd_result), 64'(fwd));
    check_eq("fack_bp",  64'(layer_backprop), 64'd0);
    layer_data_in = ~fwd;
    @(negedge clk);                                  // first BP_DRIVE cycle
    layer_valid = 1'b0; start = poke;
    check_eq("bp0_ack",  64'(layer_ack), 64'd0);
    check_eq("bp0_bp",   64'(layer_backprop), 64'd1);
    check_eq("bp0_dout", 64'(layer_data_out), 64'(t));
    check_eq("bp0_fwd",  64'(fwd_result), 64'(fwd));
    if (rst_bp) begin
      reset = 1'b0; start = 1'b0; layer_data_in = '0;
      #1;
      check_reset_vals("async_rst");
      @(negedge clk);
      reset = 1'b1;
      return;
    end
    repeat (bl) begin
      @(negedge clk);
      check_eq("bp_bp",   64'(layer_backprop), 64'd1);
      check_eq("bp_ack",  64'(layer_ack), 64'd0);
      check_eq("bp_dout", 64'(layer_data_out), 64'(t));
    end
    layer_valid = 1'b1; layer_data_in = dl;
    @(negedge clk);                                  // backprop ack cycle
    start = 1'b0;
    check_eq("back_ack",   64'(layer_ack), 64'd1);
    check_eq("back_bp",    64'(layer_backprop), 64'd0);
    check_eq("back_delta", 64'(delta_result), 64'(dl));
    layer_data_in = ~dl;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) layer_valid = 1'b0;
      check_eq("acc_done", 64'(done), 64'd0);
      check_eq("acc_busy", 64'(busy), 64'd1);
      check_eq("acc_ack",  64'(layer_ack), 64'd0);
    end
    @(negedge clk);                                  // ack + 10
    check_eq("done_pulse",  64'(done), 64'd1);
    check_eq("done_busy",   64'(busy), 64'd0);
    check_eq("done_errsum", 64'(err_sum), 64'(exp_sum));
    check_eq("done_delta",  64'(delta_result), 64'(dl));
    check_eq("done_fwd",    64'(fwd_result), 64'(fwd));
    if (hold_next) begin
      start = 1'b1; sample_in = rand_vec();
    end
  endtask

`ifdef SEQ_TIMEOUT_EN
  task automatic run_timeout();
    @(negedge clk);
    check_eq("to_idle", 64'(busy), 64'd0);
    start = 1'b1; sample_in = rand_vec(); target_in = rand_vec();
    @(negedge clk);
    start = 1'b0;
    check_eq("to_mult", 64'(layer_mult), 64'd1);
    for (int c = 2; c <= 17; c++) begin
      @(negedge clk);
      check_eq("to_wait_timeout", 64'(timeout), 64'd0);
      check_eq("to_wait_busy", 64'(busy), 64'd1);
    end
    @(negedge clk);
    check_eq("to_pulse", 64'(timeout), 64'd1);
    check_eq("to_busy",  64'(busy), 64'd0);
    check_eq("to_done",  64'(done), 64'd0);
    @(negedge clk);
    check_eq("to_pulse_end", 64'(timeout), 64'd0);
    check_eq("to_no_done",   64'(done), 64'd0);
    check_eq("to_no_mult",   64'(layer_mult), 64'd0);
  endtask
`endif

  initial begin
    int ones[L];
    int zeros[L];
    int dirs[L];
    int de[L];
    bit hold;
    int fl, bl;

    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b1;

    foreach (ones[i]) begin ones[i] = 1; zeros[i] = 0; end
    foreach (de[i]) de[i] = int'($urandom_range(127)) - 64;
    $display("step: sample ones, target zeros, fwd lat 3");
    run_step(pack(ones), pack(zeros), rand_vec(), pack(de), abs_sum(de), 3, 2, 0, 0, 0);

    dirs = '{0, -64, 63, 1, -1, 0, 0, 0, 0};
    $display("step: directed delta, expected err_sum %0d", abs_sum(dirs));
    check_eq("model_sum_129", 64'(abs_sum(dirs)), 64'd129);
    run_step(rand_vec(), rand_vec(), rand_vec(), pack(dirs), 129, 2, 4, 0, 0, 0);

    foreach (de[i]) de[i] = int'($urandom_range(127)) - 64;
    $display("step: late valid, latency %0d", LONG_LAT);
    run_step(rand_vec(), rand_vec(), rand_vec(), pack(de), abs_sum(de), LONG_LAT, LONG_LAT, 0, 0, 0);

    foreach (de[i]) de[i] = int'($urandom_range(127)) - 64;
    $display("step: start pulsed while busy");
    run_step(rand_vec(), rand_vec(), rand_vec(), pack(de), abs_sum(de), 4, 3, 1, 1, 0);

    foreach (de[i]) de[i] = int'($urandom_range(127)) - 64;
    $display("step: back-to-back start");
    run_step(rand_vec(), rand_vec(), rand_vec(), pack(de), abs_sum(de), 2, 2, 0, 0, 0);

    $display("step: reset asserted in BP_DRIVE");
    run_step(rand_vec(), rand_vec(), rand_vec(), rand_vec(), 0, 2, 2, 0, 0, 1);

    foreach (de[i]) de[i] = -64;
    $display("step: clean after reset, all -64 delta");
    run_step(rand_vec(), rand_vec(), rand_vec(), pack(de), 576, 1, 1, 0, 0, 0);

    hold = 1'b0;
    for (int n = 0; n < 10; n++) begin
      foreach (de[i]) de[i] = int'($urandom_range(127)) - 64;
      fl = int'($urandom_range(1, 8));
      bl = int'($urandom_range(1, 8));
      if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
      hold = 1'(($urandom_range(0, 1)));
      $display("step: random %0d fl=%0d bl=%0d sum=%0d hold=%0d", n, fl, bl, abs_sum(de), hold);
      run_step(rand_vec(), rand_vec(), rand_vec(), pack(de), abs_sum(de), fl, bl,
               1'($urandom_range(0, 1)), hold, 0);
    end
    @(negedge clk);
    start = 1'b0;
    if (hold) begin
      // The held start from the last step launched one more; let it finish.
      repeat (40) @(negedge clk);
      layer_valid = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
    end

`ifdef SEQ_TIMEOUT_EN
    $display("step: no answer, expect timeout");
    run_timeout();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
